// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
// Owns the fetch PC, issues word requests on an SRAM-style instruction bus,
// and buffers in-order responses in a small FIFO. The FIFO head is shown to
// the IF/ID register. A jump from EX flushes the FIFO and turns every
// in-flight response into one that is discarded when it arrives.
//
// Handshakes:
//   bus issue : a request is issued in any cycle with ibus_req_o && ibus_gnt_i.
//               Request and address carry no stability rule while ungranted.
//   bus return: ibus_rvalid_i returns one word per cycle, in issue order, at
//               least one cycle after its grant.
//   downstream: an instruction is consumed in any cycle with inst_valid_o &&
//               !hold_flag_i && !jump_flag_i.
// Credit rule: outstanding + buffered + discard never exceeds FIFO_DEPTH, so
// a returning word always has a free FIFO slot.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_head_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_disc;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [31:0]   r_mem [FIFO_DEPTH];

  logic [CW:0]   w_sum;
  logic          w_req;
  logic          w_issue;
  logic          w_drop;
  logic          w_resp;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic          w_retire;
  logic [31:0]   w_target;
  logic [CW-1:0] w_jump_disc;
  logic          w_unused_jaddr;

  // Credit check, handshake qualifiers and jump bookkeeping.
  always_comb begin
    w_sum    = {1'b0, r_out} + {1'b0, r_cnt} + {1'b0, r_disc};
    // Gated by reset so the bus sees no request while the block is held.
    w_req    = rst && !jump_flag_i && (w_sum < DEPTH_W);
    w_issue  = w_req && ibus_gnt_i;
    w_drop   = ibus_rvalid_i && (r_disc != '0);
    // A return with nothing in flight is a protocol error and is ignored.
    w_resp   = ibus_rvalid_i && (r_disc == '0) && (r_out != '0);
    w_push   = w_resp && !jump_flag_i;
    w_valid  = (r_cnt != '0);
    w_pop    = w_valid && !hold_flag_i && !jump_flag_i;
    w_target = {jump_addr_i[31:2], 2'b00};
    // Every in-flight word becomes a discard, minus the one retiring now.
    w_retire = ibus_rvalid_i && ((r_disc != '0) || (r_out != '0));
    w_jump_disc = r_disc + r_out - CW'(w_retire);
    w_unused_jaddr = ^jump_addr_i[1:0];
  end

  // Fetch PC advances per issue; head PC advances per consumed instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
    end else if (jump_flag_i) begin
      r_fetch_pc <= w_target;
      r_head_pc  <= w_target;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_pop)   r_head_pc  <= r_head_pc + 32'd4;
    end
  end

  // Outstanding, buffered and discard counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_disc <= '0;
    end else if (jump_flag_i) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_disc <= w_jump_disc;
    end else begin
      r_out  <= r_out + CW'(w_issue) - CW'(w_resp);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_disc <= r_disc - CW'(w_drop);
    end
  end

  // FIFO read/write pointers; a jump empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else if (jump_flag_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage; contents are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ibus_rdata_i;
  end

  // Outputs are combinational from state (plus the current jump for req).
  always_comb begin
    ibus_req_o   = w_req;
    ibus_addr_o  = r_fetch_pc;
    inst_valid_o = w_valid;
    inst_o       = w_valid ? r_mem[r_rptr] : INST_NOP;
    inst_addr_o  = w_valid ? r_head_pc : 32'h0;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch against a queue-based model.
module tb_ifu_fetch;

  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        jump_flag, hold_flag, ibus_gnt, ibus_rvalid;
  logic [31:0] jump_addr, ibus_rdata;
  logic        ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_o, inst_addr_o;

  ifu_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .INST_NOP(NOP)) u_dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_flag_i(hold_flag),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt),
    .ibus_rvalid_i(ibus_rvalid), .ibus_rdata_i(ibus_rdata),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  // ---------------- wrap-around DUT ----------------
  logic        wr_jump, wr_hold, wr_gnt, wr_rvalid;
  logic [31:0] wr_jaddr, wr_rdata;
  logic        wr_req, wr_valid;
  logic [31:0] wr_addr, wr_inst, wr_iaddr;

  ifu_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH), .INST_NOP(NOP)) u_wrap (
    .clk(clk), .rst(rst),
    .jump_flag_i(wr_jump), .jump_addr_i(wr_jaddr), .hold_flag_i(wr_hold),
    .ibus_req_o(wr_req), .ibus_addr_o(wr_addr), .ibus_gnt_i(wr_gnt),
    .ibus_rvalid_i(wr_rvalid), .ibus_rdata_i(wr_rdata),
    .inst_o(wr_inst), .inst_addr_o(wr_iaddr), .inst_valid_o(wr_valid)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight grants (bit 32 = stale) and buffered addresses.
  logic [31:0] m_fetch;
  logic [32:0] infl_q[$];
  logic [31:0] exp_q[$];

  // Bus responder: granted addresses and the cycle their data returns.
  logic [31:0] bus_q[$];
  int          due_q[$];
  int          last_due;

  // Wrap-instance responder state.
  logic        wr_pend;
  logic [31:0] wr_pend_addr;
  int          wg, wv;

  task automatic reset_checks(input string tag);
    check({tag, "_req"},   {31'd0, ibus_req_o},   32'd0);
    check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    check({tag, "_inst"},  inst_o,                NOP);
    check({tag, "_iaddr"}, inst_addr_o,           32'd0);
  endtask

  // ---------------- stimulus / checking loop ----------------
  initial begin
    int  lat_lo, lat_hi, gnt_pct, hold_pct, jump_pct;
    bit  in_rst, drain, m_req;
    logic [32:0] e;

    jump_flag = 0; hold_flag = 0; ibus_gnt = 0; ibus_rvalid = 0;
    jump_addr = '0; ibus_rdata = '0;
    wr_jump = 0; wr_hold = 0; wr_gnt = 1; wr_rvalid = 0; wr_jaddr = '0; wr_rdata = '0;
    wr_pend = 0; wr_pend_addr = '0; wg = 0; wv = 0;
    m_fetch = 32'h0; last_due = -1; drain = 0; in_rst = 0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b1;

    for (int cyc = 0; cyc < 520; cyc++) begin
      // phase knobs
      lat_lo = 1; lat_hi = 1; gnt_pct = 100; hold_pct = 0; jump_pct = 0;
      if (cyc >= 40 && cyc < 80) begin
        lat_lo = 1; lat_hi = 3; gnt_pct = 75; hold_pct = 20; jump_pct = 5;
      end else if (cyc >= 80 && cyc < 100) begin
        lat_lo = 3; lat_hi = 3;
      end else if (cyc >= 110 && cyc < 300) begin
        lat_lo = 1; lat_hi = 3; gnt_pct = 70; hold_pct = 25; jump_pct = 12;
      end else if (cyc >= 300 && cyc < 320) begin
        lat_lo = 3; lat_hi = 3; hold_pct = 30;
      end else if (cyc >= 322) begin
        lat_lo = 1; lat_hi = 3; gnt_pct = 80; hold_pct = 20; jump_pct = 8;
      end

      // asynchronous reset in the middle of traffic
      if (cyc == 320) begin
        rst = 1'b0;
        in_rst = 1;
        drain = 1;
        #1;
        reset_checks("rst_async");
        infl_q.delete();
        exp_q.delete();
        m_fetch = 32'h0;
      end
      if (cyc == 322) begin
        rst = 1'b1;
        in_rst = 0;
      end
      if (drain && !in_rst && bus_q.size() == 0) drain = 0;

      // drive responses
      if (bus_q.size() > 0 && due_q[0] == cyc) begin
        ibus_rvalid = 1'b1;
        ibus_rdata  = bus_q.pop_front() ^ K;
        void'(due_q.pop_front());
      end else begin
        ibus_rvalid = 1'b0;
        ibus_rdata  = $urandom;
      end

      // drive requests side
      ibus_gnt  = (in_rst || drain) ? 1'b0 : ($urandom_range(99) < gnt_pct);
      if (cyc >= 100 && cyc < 105) ibus_gnt = 1'b0;
      hold_flag = (cyc >= 30 && cyc < 36) ? 1'b1 : ($urandom_range(99) < hold_pct);
      jump_flag = !in_rst && ($urandom_range(99) < jump_pct);
      jump_addr = $urandom_range(32'h0000_3FFF);
      if (cyc == 90) begin
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0102;
      end

      wr_rvalid = wr_pend;
      wr_rdata  = wr_pend_addr ^ K;

      @(negedge clk);

      if (in_rst) begin
        reset_checks("rst_hold");
      end else begin
        m_req = !jump_flag && ((infl_q.size() + exp_q.size()) < DEPTH);
        check("req",  {31'd0, ibus_req_o}, {31'd0, m_req});
        check("addr", ibus_addr_o, m_fetch);
        if (exp_q.size() > 0) begin
          check("valid", {31'd0, inst_valid_o}, 32'd1);
          check("iaddr", inst_addr_o, exp_q[0]);
          check("inst",  inst_o, exp_q[0] ^ K);
        end else begin
          check("valid", {31'd0, inst_valid_o}, 32'd0);
          check("iaddr_idle", inst_addr_o, 32'd0);
          check("inst_idle",  inst_o, NOP);
        end

        // model update for the coming edge
        if (exp_q.size() > 0 && !hold_flag && !jump_flag) void'(exp_q.pop_front());
        if (ibus_rvalid && infl_q.size() > 0) begin
          e = infl_q.pop_front();
          if (!e[32] && !jump_flag) exp_q.push_back(e[31:0]);
        end
        if (m_req && ibus_gnt) begin
          infl_q.push_back({1'b0, m_fetch});
          m_fetch = m_fetch + 32'd4;
        end
        if (jump_flag) begin
          exp_q.delete();
          foreach (infl_q[i]) infl_q[i][32] = 1'b1;
          m_fetch = {jump_addr[31:2], 2'b00};
        end
      end

      // bus records the DUT's own grants
      if (rst && ibus_req_o && ibus_gnt) begin
        int d;
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        bus_q.push_back(ibus_addr_o);
        due_q.push_back(d);
      end

      // wrap instance: grant and output address sequences across 2^32
      if (cyc < 12) begin
        check("wrap_valid", {31'd0, wr_valid}, (cyc >= 2) ? 32'd1 : 32'd0);
        if (wr_req && wr_gnt) begin
          check("wrap_gnt_addr", wr_addr, WRAP_PC + 32'(4 * wg));
          wg++;
        end
        if (wr_valid) begin
          check("wrap_iaddr", wr_iaddr, WRAP_PC + 32'(4 * wv));
          check("wrap_inst",  wr_inst, (WRAP_PC + 32'(4 * wv)) ^ K);
          wv++;
        end
      end
      wr_pend      = rst && wr_req && wr_gnt;
      wr_pend_addr = wr_addr;

      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
